line_matrix_xbar: RTL and testbench
===================================

Name: line_matrix_xbar

Overview:
Parametrised crosspoint for discrete timing/trigger lines. Any output can be driven by any input, constant 0 or constant 1, with per-output mode: pass, invert, rising-edge pulse or falling-edge pulse. Inputs pass through optional synchronisers. Routing is programmed into shadow registers and applied atomically on commit, so multi-output reroutes never glitch. It sits between the external GPIO/trigger pins and the internal timing logic in the line matrix.

Parameters:
NUM_INPUTS, 10, number of input lines (1..64)
NUM_OUTPUTS, 10, number of output lines (1..64)
SYNC_STAGES, 2, synchroniser flops per input (0..3; 0 = inputs already in clk domain)
SEL_W, $clog2(NUM_INPUTS+2), select width (derived, not overridden)
OUT_W, max(1,$clog2(NUM_OUTPUTS)), output index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
input_lines  in  NUM_INPUTS  raw input lines
cfg_valid  in  1  config write request
cfg_ready  out  1  block can accept a write or commit
cfg_output  in  OUT_W  output index being configured
cfg_input  in  SEL_W  source select: 0 = const0, 1 = const1, k+2 = input_lines[k]
cfg_mode  in  2  0 pass, 1 invert, 2 rise-pulse, 3 fall-pulse
cfg_commit  in  1  copy all shadow settings to active (qualified by cfg_ready)
cfg_error  out  1  one-cycle pulse: rejected write
rd_output  in  OUT_W  readback index
rd_input  out  SEL_W  active select of rd_output (combinational)
rd_mode  out  2  active mode of rd_output (combinational)
output_lines  out  NUM_OUTPUTS  routed lines, registered

Behaviour:
- Reset (rst high, async): all sync flops 0; shadow and active select = 0 (const0); mode = pass; edge-history flops 0; output_lines = 0; cfg_error = 0; cfg_ready = 0. After rst deasserts, FSM enters IDLE and cfg_ready = 1 on the next clk edge.
- Reset mid-operation: discards any shadow settings that have not been committed. Outputs go to 0 immediately (async).
- Synchroniser: each input passes through SYNC_STAGES flops. The result is sync[k].
- Per-output source: src = 0, 1, or sync[sel-2], taken from the active select.
- Pass: output_lines[j] <= src. Invert: output_lines[j] <= ~src.
- Rise: output_lines[j] <= src & ~prev. Fall: output_lines[j] <= ~src & prev. prev[j] <= src every cycle.
- Latency from input pin to output, pass mode: SYNC_STAGES+1 cycles. Edge pulses are exactly 1 cycle wide, with the same latency.
- Write handshake: a write happens when cfg_valid & cfg_ready. It updates only the shadow entry for cfg_output. It has no effect on outputs until commit.
- Rejected write: cfg_output >= NUM_OUTPUTS or cfg_input > NUM_INPUTS+1. The shadow is unchanged and cfg_error = 1 in the next cycle.
- FSM states:
  - IDLE: cfg_ready = 1. A qualified cfg_commit moves to COMMIT.
  - COMMIT: one cycle, cfg_ready = 0. All active entries are loaded from shadow at the clock edge that ends COMMIT, then return to IDLE.
  - cfg_valid and cfg_commit are ignored while cfg_ready = 0.
- Simultaneous write and commit in IDLE: the write lands in shadow first and is included in that commit.
- Switch without spurious edges: on the cycle an output's active select changes, prev[j] loads the new source's current value. Rise/fall therefore fires only on real transitions after the switch.
- A commit that changes nothing leaves outputs undisturbed. Pass/invert outputs reflect the new routing one cycle after active updates.
- Readback reflects active values only.
- Unused select encodings between NUM_INPUTS+2 and 2^SEL_W-1 can never reach active registers.

Decomposition:
- Package line_matrix_pkg holds:
  - MODE_PASS = 0, MODE_INV = 1, MODE_RISE = 2, MODE_FALL = 3
  - SEL_CONST0 = 0, SEL_CONST1 = 1, SEL_BASE = 2
  - FSM state encoding IDLE/COMMIT
- One sub-module, line_matrix_cell, instantiated NUM_OUTPUTS times. Each instance holds:
  - the active select and mode
  - the source mux with constants
  - prev and the reseed-on-switch logic
  - the output flop
- The top holds the synchronisers, shadow registers, FSM, error logic and readback.

Test Plan:
Bench configuration: NUM_INPUTS = 10, NUM_OUTPUTS = 10, SYNC_STAGES = 2.
1. Reset then idle, no commit -> output_lines = 0 and rd_input = 0 for every output. cfg_ready = 1 one cycle after rst falls.
2. Write out3 = input 4 (sel = 6), pass, then commit; toggle input_lines[4] -> output_lines[3] follows 3 cycles later. Before the commit, output_lines[3] stays 0.
3. Write out0 = sel 6 rise and out1 = sel 6 fall, commit; input_lines[4] goes 0→1→0 with a 10-cycle high period -> out0 gives a 1-cycle pulse 3 cycles after the rise, out1 gives a 1-cycle pulse 3 cycles after the fall.
4. Write out2 = const1 with rise mode, commit, then reroute out2 to an input held high -> no pulse on out2 at either switch. A later 0→1 on that input gives exactly one pulse.
5. Write with cfg_output = 10, then cfg_input = 12 -> cfg_error pulses each time and readback is unchanged after commit.
6. Write out5 = sel 2 with cfg_commit in the same cycle -> cfg_ready = 0 for 1 cycle, rd_input[5] = 2 afterwards, and cfg_valid during COMMIT is ignored. Assert rst during COMMIT -> outputs 0 immediately and all selects return to 0.

Source files
------------

// File: rtl/line_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_matrix_pkg
// Desc     : Shared encodings for the line matrix crosspoint (modes, selects,
//            configuration FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package line_matrix_pkg;

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_INV  = 2'd1;
   localparam logic [1:0] MODE_RISE = 2'd2;
   localparam logic [1:0] MODE_FALL = 2'd3;

   localparam int SEL_CONST0 = 0;
   localparam int SEL_CONST1 = 1;
   localparam int SEL_BASE   = 2;

   // ST_INIT holds cfg_ready low for the first edge after reset release
   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_COMMIT = 2'd2
   } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/line_matrix_cell.sv
`default_nettype none
// ============================================================================
// Module   : line_matrix_cell
// Desc     : One crosspoint output: active route, source mux, edge history
//            and the registered output line.
// Revision : 1.0 - initial release
// ============================================================================
module line_matrix_cell #(
   parameter int NUM_INPUTS = 10,
   parameter int SEL_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_INPUTS-1:0] i_sync,
   input  logic                  i_load,
   input  logic [SEL_W-1:0]      i_load_sel,
   input  logic [1:0]            i_load_mode,
   output logic [SEL_W-1:0]      o_act_sel,
   output logic [1:0]            o_act_mode,
   output logic                  o_line
);
   import line_matrix_pkg::*;

   logic [SEL_W-1:0] r_sel;
   logic [1:0]       r_mode;
   logic             r_prev;
   logic             r_out;
   logic             w_src;
   logic             w_new_src;

   function automatic logic pick_source(input logic [SEL_W-1:0]      sel,
                                        input logic [NUM_INPUTS-1:0] lines);
      logic v;
      v = (sel == SEL_W'(SEL_CONST1));
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (sel == SEL_W'(k + SEL_BASE)) v = lines[k];
      end
      return v;
   endfunction

   assign w_src     = pick_source(r_sel, i_sync);
   assign w_new_src = pick_source(i_load_sel, i_sync);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel  <= SEL_W'(SEL_CONST0);
         r_mode <= MODE_PASS;
         r_prev <= 1'b0;
         r_out  <= 1'b0;
      end else begin
         // Reseeding history from the incoming source keeps a reroute from
         // looking like an edge.
         r_prev <= i_load ? w_new_src : w_src;
         case (r_mode)
            MODE_PASS: r_out <= w_src;
            MODE_INV:  r_out <= ~w_src;
            MODE_RISE: r_out <= w_src & ~r_prev;
            default:   r_out <= ~w_src & r_prev;
         endcase
         if (i_load) begin
            r_sel  <= i_load_sel;
            r_mode <= i_load_mode;
         end
      end
   end

   assign o_act_sel  = r_sel;
   assign o_act_mode = r_mode;
   assign o_line     = r_out;

endmodule
`default_nettype wire

// File: rtl/line_matrix_xbar.sv
`default_nettype none
// ============================================================================
// Module   : line_matrix_xbar
// Desc     : Crosspoint for timing/trigger lines with synchronisers, shadow
//            routing registers and atomic commit.
// Revision : 1.0 - initial release
// ============================================================================
module line_matrix_xbar #(
   parameter int NUM_INPUTS  = 10,
   parameter int NUM_OUTPUTS = 10,
   parameter int SYNC_STAGES = 2,
   parameter int SEL_W       = $clog2(NUM_INPUTS + 2),
   parameter int OUT_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_INPUTS-1:0]  input_lines,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [OUT_W-1:0]       cfg_output,
   input  logic [SEL_W-1:0]       cfg_input,
   input  logic [1:0]             cfg_mode,
   input  logic                   cfg_commit,
   output logic                   cfg_error,
   input  logic [OUT_W-1:0]       rd_output,
   output logic [SEL_W-1:0]       rd_input,
   output logic [1:0]             rd_mode,
   output logic [NUM_OUTPUTS-1:0] output_lines
);
   import line_matrix_pkg::*;

   localparam logic [OUT_W:0]   c_num_out = (OUT_W + 1)'(NUM_OUTPUTS);
   localparam logic [SEL_W-1:0] c_max_sel = SEL_W'(NUM_INPUTS + 1);

   fsm_state_t            r_state;
   logic                  r_cfg_ready;
   logic                  r_cfg_error;
   logic [NUM_INPUTS-1:0] w_sync;
   logic                  w_wr;
   logic                  w_bad;
   logic                  w_wr_ok;
   logic                  w_load;
   logic [SEL_W-1:0]      w_act_sel  [NUM_OUTPUTS];
   logic [1:0]            w_act_mode [NUM_OUTPUTS];

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_sync = input_lines;
      end else begin : g_sync
         logic [NUM_INPUTS-1:0] r_sync [SYNC_STAGES];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            end else begin
               r_sync[0] <= input_lines;
               for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            end
         end
         assign w_sync = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_wr    = cfg_valid & r_cfg_ready;
   assign w_bad   = ({1'b0, cfg_output} >= c_num_out) || (cfg_input > c_max_sel);
   assign w_wr_ok = w_wr & ~w_bad;
   assign w_load  = (r_state == ST_COMMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_cfg_ready <= 1'b0;
         r_cfg_error <= 1'b0;
      end else begin
         r_cfg_error <= w_wr & w_bad;
         case (r_state)
            ST_INIT: begin
               r_state     <= ST_IDLE;
               r_cfg_ready <= 1'b1;
            end
            ST_IDLE: begin
               // A write in the same cycle lands in shadow before COMMIT copies it
               if (cfg_commit) begin
                  r_state     <= ST_COMMIT;
                  r_cfg_ready <= 1'b0;
               end
            end
            ST_COMMIT: begin
               r_state     <= ST_IDLE;
               r_cfg_ready <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   generate
      for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_out
         logic [SEL_W-1:0] r_shadow_sel;
         logic [1:0]       r_shadow_mode;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_shadow_sel  <= SEL_W'(SEL_CONST0);
               r_shadow_mode <= MODE_PASS;
            end else if (w_wr_ok && (cfg_output == OUT_W'(j))) begin
               r_shadow_sel  <= cfg_input;
               r_shadow_mode <= cfg_mode;
            end
         end

         line_matrix_cell #(
            .NUM_INPUTS (NUM_INPUTS),
            .SEL_W      (SEL_W)
         ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .i_sync      (w_sync),
            .i_load      (w_load),
            .i_load_sel  (r_shadow_sel),
            .i_load_mode (r_shadow_mode),
            .o_act_sel   (w_act_sel[j]),
            .o_act_mode  (w_act_mode[j]),
            .o_line      (output_lines[j])
         );
      end
   endgenerate

   always_comb begin
      rd_input = '0;
      rd_mode  = MODE_PASS;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
         if (rd_output == OUT_W'(j)) begin
            rd_input = w_act_sel[j];
            rd_mode  = w_act_mode[j];
         end
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign cfg_error = r_cfg_error;

endmodule
`default_nettype wire

// File: tb/tb_line_matrix_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_matrix_xbar
// Desc     : Directed self-checking bench for line_matrix_xbar (10x10, 2 sync).
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_matrix_xbar;

   localparam int NI = 10;
   localparam int NO = 10;
   localparam int SS = 2;
   localparam int SW = 4;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NI-1:0] input_lines;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [OW-1:0] cfg_output;
   logic [SW-1:0] cfg_input;
   logic [1:0]    cfg_mode;
   logic          cfg_commit;
   logic          cfg_error;
   logic [OW-1:0] rd_output;
   logic [SW-1:0] rd_input;
   logic [1:0]    rd_mode;
   logic [NO-1:0] output_lines;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   line_matrix_xbar #(
      .NUM_INPUTS  (NI),
      .NUM_OUTPUTS (NO),
      .SYNC_STAGES (SS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .input_lines  (input_lines),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_output   (cfg_output),
      .cfg_input    (cfg_input),
      .cfg_mode     (cfg_mode),
      .cfg_commit   (cfg_commit),
      .cfg_error    (cfg_error),
      .rd_output    (rd_output),
      .rd_input     (rd_input),
      .rd_mode      (rd_mode),
      .output_lines (output_lines)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_write(input logic [OW-1:0] o, input logic [SW-1:0] s,
                            input logic [1:0] m, input logic commit, input logic exp_err);
      cfg_valid  = 1'b1;
      cfg_output = o;
      cfg_input  = s;
      cfg_mode   = m;
      cfg_commit = commit;
      tick(1);
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      check("cfg_error", 32'(cfg_error), 32'(exp_err));
   endtask

   task automatic do_commit();
      cfg_commit = 1'b1;
      tick(1);
      cfg_commit = 1'b0;
      check("commit_busy", 32'(cfg_ready), 0);
      tick(1);
   endtask

   task automatic check_rd(input logic [OW-1:0] o, input int exp_sel, input int exp_mode);
      rd_output = o;
      #1;
      check("rd_input", 32'(rd_input), exp_sel);
      check("rd_mode", 32'(rd_mode), exp_mode);
   endtask

   initial begin
      input_lines = '0;
      cfg_valid   = 1'b0;
      cfg_output  = '0;
      cfg_input   = '0;
      cfg_mode    = 2'd0;
      cfg_commit  = 1'b0;
      rd_output   = '0;

      // Reset and idle
      tick(3);
      check("rst_ready", 32'(cfg_ready), 0);
      check("rst_out", 32'(output_lines), 0);
      rst = 1'b0;
      #1;
      check("ready_pre_edge", 32'(cfg_ready), 0);
      tick(1);
      check("ready_up", 32'(cfg_ready), 1);
      for (int j = 0; j < NO; j++) check_rd(OW'(j), 0, 0);
      check("idle_out", 32'(output_lines), 0);

      // Pass route out3 <- input 4, invisible until commit
      cfg_write(4'd3, 4'd6, 2'd0, 1'b0, 1'b0);
      input_lines[4] = 1'b1;
      tick(4);
      check("out3_precommit", 32'(output_lines[3]), 0);
      check_rd(4'd3, 0, 0);
      do_commit();
      tick(1);
      check("out3_after_commit", 32'(output_lines[3]), 1);
      check_rd(4'd3, 6, 0);
      input_lines[4] = 1'b0;
      tick(2);
      check("out3_lat2", 32'(output_lines[3]), 1);
      tick(1);
      check("out3_lat3_fall", 32'(output_lines[3]), 0);
      input_lines[4] = 1'b1;
      tick(2);
      check("out3_lat2_rise", 32'(output_lines[3]), 0);
      tick(1);
      check("out3_lat3_rise", 32'(output_lines[3]), 1);
      input_lines[4] = 1'b0;
      tick(4);

      // Rise/fall pulses from input 4
      cfg_write(4'd0, 4'd6, 2'd2, 1'b0, 1'b0);
      cfg_write(4'd1, 4'd6, 2'd3, 1'b0, 1'b0);
      do_commit();
      tick(2);
      check("out0_quiet", 32'(output_lines[0]), 0);
      check("out1_quiet", 32'(output_lines[1]), 0);
      input_lines[4] = 1'b1;
      tick(2);
      check("rise_early", 32'(output_lines[0]), 0);
      tick(1);
      check("rise_pulse", 32'(output_lines[0]), 1);
      check("fall_on_rise", 32'(output_lines[1]), 0);
      tick(1);
      check("rise_width", 32'(output_lines[0]), 0);
      tick(6);
      input_lines[4] = 1'b0;
      tick(2);
      check("fall_early", 32'(output_lines[1]), 0);
      tick(1);
      check("fall_pulse", 32'(output_lines[1]), 1);
      check("rise_on_fall", 32'(output_lines[0]), 0);
      tick(1);
      check("fall_width", 32'(output_lines[1]), 0);

      // No spurious edges on reroute
      input_lines[7] = 1'b1;
      cfg_write(4'd2, 4'd1, 2'd2, 1'b0, 1'b0);
      do_commit();
      for (int t = 0; t < 3; t++) begin
         check("switch_const1", 32'(output_lines[2]), 0);
         tick(1);
      end
      cfg_write(4'd2, 4'd9, 2'd2, 1'b0, 1'b0);
      do_commit();
      for (int t = 0; t < 3; t++) begin
         check("switch_in7", 32'(output_lines[2]), 0);
         tick(1);
      end
      check_rd(4'd2, 9, 2);
      input_lines[7] = 1'b0;
      tick(4);
      check("in7_fall_no_pulse", 32'(output_lines[2]), 0);
      input_lines[7] = 1'b1;
      tick(2);
      check("in7_rise_early", 32'(output_lines[2]), 0);
      tick(1);
      check("in7_rise_pulse", 32'(output_lines[2]), 1);
      for (int t = 0; t < 3; t++) begin
         tick(1);
         check("in7_single_pulse", 32'(output_lines[2]), 0);
      end

      // Rejected writes and boundary selects
      cfg_write(4'd10, 4'd3, 2'd0, 1'b0, 1'b1);
      tick(1);
      check("error_width", 32'(cfg_error), 0);
      cfg_write(4'd4, 4'd12, 2'd1, 1'b0, 1'b1);
      cfg_write(4'd9, 4'd11, 2'd1, 1'b0, 1'b0);
      do_commit();
      check_rd(4'd4, 0, 0);
      check_rd(4'd3, 6, 0);
      check_rd(4'd9, 11, 1);
      tick(1);
      check("out9_inv", 32'(output_lines[9]), 1);

      // Write with commit, ignored traffic during COMMIT
      cfg_write(4'd8, 4'd1, 2'd0, 1'b0, 1'b0);
      cfg_write(4'd5, 4'd2, 2'd0, 1'b1, 1'b0);
      check("commit_ready", 32'(cfg_ready), 0);
      check_rd(4'd5, 0, 0);
      cfg_valid  = 1'b1;
      cfg_output = 4'd6;
      cfg_input  = 4'd3;
      cfg_mode   = 2'd1;
      cfg_commit = 1'b1;
      tick(1);
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      check("ready_back", 32'(cfg_ready), 1);
      check_rd(4'd5, 2, 0);
      check_rd(4'd8, 1, 0);
      tick(1);
      check("no_second_commit", 32'(cfg_ready), 1);
      do_commit();
      check_rd(4'd6, 0, 0);
      check("out8_const1", 32'(output_lines[8]), 1);

      // Async reset during COMMIT
      cfg_write(4'd7, 4'd4, 2'd0, 1'b1, 1'b0);
      check("commit_ready2", 32'(cfg_ready), 0);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_out", 32'(output_lines), 0);
      check("async_rst_ready", 32'(cfg_ready), 0);
      tick(2);
      rst = 1'b0;
      tick(1);
      check("ready_after_rst", 32'(cfg_ready), 1);
      do_commit();
      for (int j = 0; j < NO; j++) check_rd(OW'(j), 0, 0);
      tick(1);
      check("out_after_rst", 32'(output_lines), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
